// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver with a receive FIFO, sticky error flags and a level interrupt.
// Registers: DATA (pop), STATUS (read-clear sticky bits), DIVISOR, IRQ_EN, decoded on addr_i[3:2].
module uart_rx_periph #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd434
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        sel_i,
  input  logic        wr_i,
  input  logic        rx_i,
  output logic        irq_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [15:0] cnt_r, cnt_s;
  logic [2:0]  bit_idx_r, bit_idx_s;
  logic [7:0]  shift_r, shift_s;
  logic [15:0] div_lat_r, div_lat_s;
  logic        push_s, frame_evt_s;

  logic        rx_meta_r, rx_sync_r, rx_prev_r;
  logic [1:0]  settle_r;
  logic        start_edge_s;

  logic [15:0] divisor_r;
  logic        irq_en_r, overrun_r, frame_err_r;
  logic [7:0]  mem_r [FIFO_DEPTH];
  logic [AW:0] wr_ptr_r, rd_ptr_r;
  logic        empty_s, full_s, pop_s, push_ok_s, overrun_evt_s;
  logic        rd_cyc_s, wr_cyc_s, stat_rd_s;
  logic [31:0] rd_data_s;
  logic [15:0] div_wr_s;
  logic        unused_s;

  assign unused_s = ^{addr_i[31:4], addr_i[1:0], data_i[31:16]};

  // Two-flop synchroniser, edge-detect history and post-reset settle counter
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
      settle_r  <= 2'd0;
    end else begin
      rx_meta_r <= rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
      settle_r  <= (settle_r == 2'd3) ? 2'd3 : settle_r + 2'd1;
    end
  end

  // The flops reset high, so a line held low through reset would look like an edge until they flush
  assign start_edge_s = (settle_r == 2'd3) & rx_prev_r & ~rx_sync_r;

  // Receiver state and datapath registers
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'd0;
      div_lat_r <= DIV_RESET;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      bit_idx_r <= bit_idx_s;
      shift_r   <= shift_s;
      div_lat_r <= div_lat_s;
    end
  end

  // Receiver next-state logic; each bit period reloads the counter from the latched divisor
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    bit_idx_s   = bit_idx_r;
    shift_s     = shift_r;
    div_lat_s   = div_lat_r;
    push_s      = 1'b0;
    frame_evt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_edge_s) begin
          state_s   = ST_START;
          div_lat_s = divisor_r;
          cnt_s     = (divisor_r >> 1) - 16'd1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (cnt_r != 16'd0) begin
          cnt_s = cnt_r - 16'd1;
        end else if (rx_sync_r) begin
          state_s = ST_IDLE;
        end else begin
          state_s   = ST_DATA;
          cnt_s     = div_lat_r - 16'd1;
          bit_idx_s = 3'd0;
        end
      end
      ST_DATA: begin
        if (cnt_r != 16'd0) begin
          cnt_s = cnt_r - 16'd1;
        end else begin
          shift_s = {rx_sync_r, shift_r[7:1]};
          cnt_s   = div_lat_r - 16'd1;
          if (bit_idx_r == 3'd7) begin
            state_s = ST_STOP;
          end else begin
            bit_idx_s = bit_idx_r + 3'd1;
          end
        end
      end
      ST_STOP: begin
        if (cnt_r != 16'd0) begin
          cnt_s = cnt_r - 16'd1;
        end else begin
          state_s = ST_IDLE;
          if (rx_sync_r) begin
            push_s = 1'b1;
          end else begin
            frame_evt_s = 1'b1;
          end
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  assign empty_s   = (wr_ptr_r == rd_ptr_r);
  assign full_s    = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign rd_cyc_s  = sel_i & ~wr_i;
  assign wr_cyc_s  = sel_i & wr_i;
  assign pop_s     = rd_cyc_s & (addr_i[3:2] == 2'd0) & ~empty_s;
  assign stat_rd_s = rd_cyc_s & (addr_i[3:2] == 2'd1);
  // A same-edge pop frees the slot, so a push into a full FIFO only overruns without one
  assign push_ok_s     = push_s & (~full_s | pop_s);
  assign overrun_evt_s = push_s & full_s & ~pop_s;
  assign div_wr_s      = (data_i[15:0] < 16'd4) ? 16'd4 : data_i[15:0];

  // Read mux
  always_comb begin
    rd_data_s = 32'd0;
    case (addr_i[3:2])
      2'd0: begin
        if (empty_s) begin
          rd_data_s = 32'd0;
        end else begin
          rd_data_s = {24'd0, mem_r[rd_ptr_r[AW-1:0]]};
        end
      end
      2'd1:    rd_data_s = {28'd0, frame_err_r, overrun_r, full_s, ~empty_s};
      2'd2:    rd_data_s = {16'd0, divisor_r};
      2'd3:    rd_data_s = {31'd0, irq_en_r};
      default: rd_data_s = 32'd0;
    endcase
  end

  // FIFO storage
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
    end
  end

  // Bus registers, FIFO pointers, sticky flags and registered outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      divisor_r   <= DIV_RESET;
      irq_en_r    <= 1'b0;
      overrun_r   <= 1'b0;
      frame_err_r <= 1'b0;
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      data_o      <= 32'd0;
      irq_o       <= 1'b0;
    end else begin
      if (wr_cyc_s && addr_i[3:2] == 2'd2) begin
        divisor_r <= div_wr_s;
      end
      if (wr_cyc_s && addr_i[3:2] == 2'd3) begin
        irq_en_r <= data_i[0];
      end
      if (rd_cyc_s) begin
        data_o <= rd_data_s;
      end
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      overrun_r   <= overrun_evt_s | (overrun_r & ~stat_rd_s);
      frame_err_r <= frame_evt_s | (frame_err_r & ~stat_rd_s);
      irq_o       <= irq_en_r & ~empty_s;
    end
  end

endmodule
